// File: rtl/rs_mul_param.sv
// rs_mul_param: collapsing-queue reservation station feeding a pipelined 32x32 multiplier with writeback forwarding
module rs_mul_param #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int NWB = 3,
  parameter int MUL_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hci_rdy,
  input  logic                     flush,
  input  logic                     in_en,
  input  logic [2:0]               op_type,
  input  logic [TAG_W-1:0]         vdest_id,
  input  logic                     op1_dependent,
  input  logic                     op2_dependent,
  input  logic [31:0]              op1,
  input  logic [31:0]              op2,
  input  logic [NWB-1:0]           wb_en,
  input  logic [NWB*TAG_W-1:0]     wb_tag,
  input  logic [NWB*32-1:0]        wb_val,
  output logic                     writeback_en,
  output logic [TAG_W-1:0]         writeback_vregid,
  output logic [31:0]              writeback_val,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             d1;
    logic             d2;
    logic [31:0]      v1;
    logic [31:0]      v2;
  } ent_t;
  ent_t q [DEPTH];
  ent_t nq [DEPTH];
  ent_t inc, ie;
  logic any_rdy, direct, store, iss;
  logic [IW-1:0] sel;
  logic [CW-1:0] tail, n_cnt;
  logic signed [32:0] a33, b33;
  logic signed [63:0] prod;
  logic [31:0] res;
  logic [MUL_LAT-1:0] pv;
  logic [TAG_W-1:0] p_tag [MUL_LAT];
  logic [31:0] p_res [MUL_LAT];
  function automatic ent_t snoop(input ent_t e);
    ent_t r = e;
    for (int p = NWB - 1; p >= 0; p--) begin
      if (e.d1 && wb_en[p] && wb_tag[p*TAG_W +: TAG_W] == e.v1[TAG_W-1:0]) begin
        r.d1 = 1'b0;
        r.v1 = wb_val[p*32 +: 32];
      end
      if (e.d2 && wb_en[p] && wb_tag[p*TAG_W +: TAG_W] == e.v2[TAG_W-1:0]) begin
        r.d2 = 1'b0;
        r.v2 = wb_val[p*32 +: 32];
      end
    end
    return r;
  endfunction
  always_comb begin
    any_rdy = 1'b0;
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (CW'(i) < count && !q[i].d1 && !q[i].d2) begin
        any_rdy = 1'b1;
        sel = IW'(i);
      end
    inc = snoop('{op: op_type, tag: vdest_id, d1: op1_dependent, d2: op2_dependent, v1: op1, v2: op2});
    direct = in_en && !inc.d1 && !inc.d2 && !any_rdy;
    store = in_en && !direct && (count != CW'(DEPTH) || any_rdy);
    iss = any_rdy || direct;
    ie = any_rdy ? q[sel] : inc;
    tail = count - CW'(any_rdy);
    n_cnt = count + CW'(store) - CW'(any_rdy);
    for (int i = 0; i < DEPTH; i++)
      nq[i] = snoop((store && CW'(i) == tail) ? inc :
                    (any_rdy && IW'(i) >= sel) ? q[i == DEPTH - 1 ? i : i + 1] : q[i]);
    a33 = {ie.op != 3'b011 && ie.v1[31], ie.v1};
    b33 = {(ie.op == 3'b000 || ie.op == 3'b001) && ie.v2[31], ie.v2};
    prod = a33 * b33;
    res = ie.op[2] ? 32'd0 : ie.op == 3'b000 ? prod[31:0] : prod[63:32];
  end
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      full <= 1'b0;
      pv <= '0;
      writeback_en <= 1'b0;
      writeback_vregid <= '0;
      writeback_val <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        p_tag[i] <= '0;
        p_res[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      full <= 1'b0;
      pv <= '0;
      writeback_en <= 1'b0;
    end else if (hci_rdy) begin
      q <= nq;
      count <= n_cnt;
      full <= n_cnt == CW'(DEPTH);
      pv[0] <= iss;
      p_tag[0] <= ie.tag;
      p_res[0] <= res;
      for (int i = 1; i < MUL_LAT; i++) begin
        pv[i] <= pv[i-1];
        p_tag[i] <= p_tag[i-1];
        p_res[i] <= p_res[i-1];
      end
      writeback_en <= pv[MUL_LAT-1];
      writeback_vregid <= p_tag[MUL_LAT-1];
      writeback_val <= p_res[MUL_LAT-1];
    end
endmodule

// File: tb/tb_rs_mul_param.sv
// tb_rs_mul_param: directed table and sequence checks for rs_mul_param
module tb_rs_mul_param;
  logic clk = 1'b0;
  logic rst = 1'b1, hci_rdy = 1'b1, flush = 1'b0, in_en = 1'b0;
  logic [2:0] op_type = '0;
  logic [4:0] vdest_id = '0;
  logic op1_dependent = 1'b0, op2_dependent = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [2:0] wb_en = '0;
  logic [14:0] wb_tag = '0;
  logic [95:0] wb_val = '0;
  logic writeback_en, full;
  logic [4:0] writeback_vregid;
  logic [31:0] writeback_val;
  logic [3:0] count;
  int tests = 0, fails = 0;
  int et [16];
  int ev [16];
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  t;
    logic [31:0] exp;
  } vec_t;
  vec_t v [12];
  always #5 clk = ~clk;
  rs_mul_param dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .flush(flush), .in_en(in_en),
    .op_type(op_type), .vdest_id(vdest_id), .op1_dependent(op1_dependent),
    .op2_dependent(op2_dependent), .op1(op1), .op2(op2), .wb_en(wb_en),
    .wb_tag(wb_tag), .wb_val(wb_val), .writeback_en(writeback_en),
    .writeback_vregid(writeback_vregid), .writeback_val(writeback_val),
    .full(full), .count(count)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, input logic d1, input logic [31:0] a,
                      input logic d2, input logic [31:0] b, input logic [4:0] t);
    in_en = 1'b1;
    op_type = op;
    op1_dependent = d1;
    op1 = a;
    op2_dependent = d2;
    op2 = b;
    vdest_id = t;
  endtask
  task automatic idle();
    in_en = 1'b0;
    op1_dependent = 1'b0;
    op2_dependent = 1'b0;
  endtask
  task automatic wake_drain(input logic [4:0] wtag, input logic [31:0] wv, input int n);
    wb_en = 3'b001;
    wb_tag = {10'd0, wtag};
    wb_val = {64'd0, wv};
    @(negedge clk);
    wb_en = '0;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("drain_count_first", count, n - 1);
      if (k >= 4) begin
        chk("drain_en", writeback_en, 1);
        chk("drain_tag", writeback_vregid, et[k-4]);
        chk("drain_val", writeback_val, ev[k-4]);
      end
    end
    chk("drain_count_end", count, 0);
    chk("drain_full_end", full, 0);
  endtask
  initial begin
    v[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 5'd4,  32'hFFFFFFEB};
    v[1]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE};
    v[2]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'h00000000};
    v[3]  = '{3'b010, 32'hFFFFFFFF,   32'd2,        5'd3,  32'hFFFFFFFF};
    v[4]  = '{3'b000, 32'h00010000,   32'h00010000, 5'd5,  32'h00000000};
    v[5]  = '{3'b011, 32'h00010000,   32'h00010000, 5'd6,  32'h00000001};
    v[6]  = '{3'b001, 32'h80000000,   32'h80000000, 5'd7,  32'h40000000};
    v[7]  = '{3'b010, 32'h80000000,   32'h80000000, 5'd8,  32'hC0000000};
    v[8]  = '{3'b011, 32'h80000000,   32'h80000000, 5'd9,  32'h40000000};
    v[9]  = '{3'b100, 32'd5,          32'd6,        5'd10, 32'h00000000};
    v[10] = '{3'b000, 32'd12345,      32'd1000,     5'd11, 32'h00BC5EA8};
    v[11] = '{3'b001, 32'd7,          32'hFFFFFFFD, 5'd12, 32'hFFFFFFFF};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_en", writeback_en, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_tag", writeback_vregid, 0);
    chk("rst_val", writeback_val, 0);
    for (int t = 0; t < 16; t++) begin
      if (t >= 4) begin
        chk("vec_en", writeback_en, 1);
        chk("vec_tag", writeback_vregid, v[t-4].t);
        chk("vec_val", writeback_val, v[t-4].exp);
      end
      if (t >= 1) chk("vec_count", count, 0);
      if (t < 12) send(v[t].op, 1'b0, v[t].a, 1'b0, v[t].b, v[t].t);
      else idle();
      @(negedge clk);
    end
    chk("vec_idle_en", writeback_en, 0);
    for (int i = 0; i < 8; i++) begin
      send(3'b000, 1'b1, 32'd9, 1'b0, i + 1, 5'(10 + i));
      et[i] = 10 + i;
      ev[i] = 5 * (i + 1);
      @(negedge clk);
    end
    idle();
    chk("fill_count", count, 8);
    chk("fill_full", full, 1);
    send(3'b000, 1'b1, 32'd9, 1'b0, 32'd50, 5'd20);
    @(negedge clk);
    idle();
    chk("ninth_ignored", count, 8);
    chk("ninth_full", full, 1);
    wake_drain(5'd9, 32'd5, 8);
    for (int i = 0; i < 8; i++) begin
      send(3'b000, 1'b1, i == 2 ? 32'd7 : 32'd9, 1'b0, i + 1, 5'(10 + i));
      @(negedge clk);
    end
    idle();
    wb_en = 3'b001;
    wb_tag = {10'd0, 5'd7};
    wb_val = {64'd0, 32'd3};
    @(negedge clk);
    wb_en = '0;
    send(3'b000, 1'b1, 32'd9, 1'b0, 32'd100, 5'd25);
    @(negedge clk);
    idle();
    chk("collapse_count", count, 8);
    chk("collapse_full", full, 1);
    repeat (3) @(negedge clk);
    chk("slot2_en", writeback_en, 1);
    chk("slot2_tag", writeback_vregid, 12);
    chk("slot2_val", writeback_val, 9);
    et[0] = 10; et[1] = 11; et[2] = 13; et[3] = 14;
    et[4] = 15; et[5] = 16; et[6] = 17; et[7] = 25;
    ev[0] = 2;  ev[1] = 4;  ev[2] = 8;  ev[3] = 10;
    ev[4] = 12; ev[5] = 14; ev[6] = 16; ev[7] = 200;
    wake_drain(5'd9, 32'd2, 8);
    send(3'b000, 1'b1, 32'd6, 1'b0, 32'd4, 5'd8);
    wb_en = 3'b100;
    wb_tag = {5'd6, 5'd0, 5'd0};
    wb_val = {32'd11, 32'd0, 32'd0};
    @(negedge clk);
    send(3'b000, 1'b1, 32'd6, 1'b1, 32'd5, 5'd9);
    wb_en = 3'b111;
    wb_tag = {5'd6, 5'd6, 5'd5};
    wb_val = {32'd99, 32'd11, 32'd3};
    @(negedge clk);
    idle();
    wb_en = '0;
    chk("fwd_count", count, 0);
    repeat (2) @(negedge clk);
    chk("fwd_p2_en", writeback_en, 1);
    chk("fwd_p2_tag", writeback_vregid, 8);
    chk("fwd_p2_val", writeback_val, 44);
    @(negedge clk);
    chk("fwd_prio_tag", writeback_vregid, 9);
    chk("fwd_prio_val", writeback_val, 33);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send(3'b000, 1'b1, 32'd9, 1'b0, 32'd1, 5'(10 + i));
      @(negedge clk);
    end
    send(3'b000, 1'b0, 32'd2, 1'b0, 32'd3, 5'd1);
    @(negedge clk);
    send(3'b000, 1'b0, 32'd4, 1'b0, 32'd5, 5'd2);
    @(negedge clk);
    chk("preflush_count", count, 5);
    flush = 1'b1;
    send(3'b000, 1'b0, 32'd1, 1'b0, 32'd1, 5'd3);
    @(negedge clk);
    flush = 1'b0;
    idle();
    chk("flush_count", count, 0);
    chk("flush_full", full, 0);
    for (int i = 0; i < 5; i++) begin
      chk("flush_no_wb", writeback_en, 0);
      @(negedge clk);
    end
    wb_en = 3'b001;
    wb_tag = {10'd0, 5'd9};
    wb_val = {64'd0, 32'd1};
    @(negedge clk);
    wb_en = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_wake_no_wb", writeback_en, 0);
    end
    chk("flush_wake_count", count, 0);
    send(3'b000, 1'b0, 32'd6, 1'b0, 32'd7, 5'd3);
    @(negedge clk);
    idle();
    @(negedge clk);
    hci_rdy = 1'b0;
    send(3'b000, 1'b0, 32'd1, 1'b0, 32'd1, 5'd30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_en", writeback_en, 0);
      chk("stall_count", count, 0);
    end
    hci_rdy = 1'b1;
    idle();
    @(negedge clk);
    chk("stall_late_en", writeback_en, 0);
    @(negedge clk);
    chk("stall_out_en", writeback_en, 1);
    chk("stall_out_tag", writeback_vregid, 3);
    chk("stall_out_val", writeback_val, 42);
    hci_rdy = 1'b0;
    @(negedge clk);
    chk("hold_en", writeback_en, 1);
    chk("hold_val", writeback_val, 42);
    hci_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_after_en", writeback_en, 0);
    end
    send(3'b000, 1'b0, 32'd3, 1'b0, 32'd3, 5'd7);
    @(negedge clk);
    rst = 1'b1;
    send(3'b000, 1'b0, 32'd2, 1'b0, 32'd2, 5'd8);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("midrst_count", count, 0);
    chk("midrst_tag", writeback_vregid, 0);
    chk("midrst_val", writeback_val, 0);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_wb", writeback_en, 0);
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_mul_param.md
RS_MUL_PARAM -- requirements
Module: rs_mul_param

Interface
REQ-001 Parameter DEPTH, default 8: number of station entries (power of two, 2..32).
REQ-002 Parameter TAG_W, default 5: width of a virtual-register tag.
REQ-003 Parameter NWB, default 3: number of writeback (broadcast) ports snooped.
REQ-004 Parameter MUL_LAT, default 3: multiplier pipeline depth in cycles (1..8).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 hci_rdy  in  1  global enable; low freezes every register, outputs included.
REQ-008 flush  in  1  discards all entries and all in-flight multiplies.
REQ-009 in_en  in  1  dispatch strobe for one new multiply.
REQ-010 op_type  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is reserved.
REQ-011 vdest_id  in  TAG_W  destination tag.
REQ-012 op1_dependent / op2_dependent  in  1  operand waits on a tag held in opN[TAG_W-1:0].
REQ-013 op1 / op2  in  32  operand value, or tag when dependent.
REQ-014 wb_en  in  NWB  per-port writeback valid.
REQ-015 wb_tag  in  NWB*TAG_W  port p tag in bits [p*TAG_W +: TAG_W].
REQ-016 wb_val  in  NWB*32  port p value in bits [p*32 +: 32].
REQ-017 writeback_en  out  1  result valid, registered.
REQ-018 writeback_vregid  out  TAG_W  result tag, registered.
REQ-019 writeback_val  out  32  result value, registered.
REQ-020 full  out  1  registered; high when the entry count equals DEPTH.
REQ-021 count  out  $clog2(DEPTH)+1  registered number of occupied entries.

Function
REQ-022 Entries form an age-ordered collapsing queue: slot 0 is oldest, and slots 0..count-1 are occupied.
REQ-023 An entry is ready when both of its stored dependent flags are 0.
REQ-024 Selection picks the lowest-index ready slot, which is the oldest ready entry.
REQ-025 When the selected slot k is removed, slots k+1..count-1 shift down by one in the same edge.
REQ-026 An incoming op is forwarded before capture: a dependent operand whose tag matches an enabled wb port takes that port's value and is marked not-dependent.
REQ-027 If several wb ports match, the lowest port index wins.
REQ-028 Direct issue: an incoming op that is ready after forwarding, arriving while no queued entry is ready, enters the multiplier directly and is never stored.
REQ-029 Otherwise an incoming op with in_en=1 is written to the tail slot, after any collapse in the same edge.
REQ-030 in_en while full=1 and no issue occurs in that cycle is ignored: no state change.
REQ-031 A stored dependent operand matching an enabled wb port captures the value and clears its flag at that edge.
REQ-032 The capture in REQ-031 is visible to selection from the next cycle onward.
REQ-033 Writeback capture applies to the entry at its post-collapse position.
REQ-034 The multiplier is fully pipelined; it accepts at most one op per cycle and never stalls.
REQ-035 An op issued at edge E produces writeback_en=1 after edge E+MUL_LAT; there are no bubbles between back-to-back issues.
REQ-036 Signedness: MUL and MULH use signed x signed, MULHSU uses signed x unsigned, MULHU uses unsigned x unsigned.
REQ-037 The 64-bit product is formed from 33-bit sign- or zero-extended operands.
REQ-038 writeback_val is the low 32 bits of the product for MUL and the high 32 bits for all other ops.
REQ-039 A reserved op_type is accepted and produces writeback_val=0 at normal latency.
REQ-040 count_next = count + stored - issued_from_queue.
REQ-041 full and count are registered from count_next.
REQ-042 flush=1: all slots are emptied, pipeline valid bits are cleared, and count=0, full=0, writeback_en=0 after the edge.
REQ-043 Under flush=1, in_en in the same cycle is discarded.
REQ-044 hci_rdy=0 holds queue, pipeline, count, full and writeback outputs unchanged.
REQ-045 Under hci_rdy=0, in_en is ignored.
REQ-046 rst and flush take priority over hci_rdy=0.

Reset
REQ-047 rst=1 at an edge sets writeback_en=0, full=0, count=0, all slots empty and all pipeline valid bits 0.
REQ-048 Under rst, writeback_vregid and writeback_val are 0.
REQ-049 rst asserted mid-multiply drops the multiply with no later writeback.
REQ-050 rst overrides in_en in the same cycle.

Verification
REQ-051 Ready MUL op1=7, op2=-3, vdest=4 into an empty station -> after MUL_LAT edges: writeback_en=1, vregid=4, val=0xFFFFFFEB; count stays 0.
REQ-052 MULHU 0xFFFFFFFF*0xFFFFFFFF -> val=0xFFFFFFFE; MULH with the same operands -> val=0; MULHSU -1*2 -> val=0xFFFFFFFF.
REQ-053 Fill the queue with 8 ops dependent on tag 9 -> full=1, count=8, and a 9th in_en is ignored; wb tag 9 val 5 -> issue from slot 0 next cycle, and the remaining 7 entries issue on consecutive cycles.
REQ-054 Slot 2 becomes ready before slot 0 -> slot 2 issues first and slots 3..7 collapse; a simultaneous in_en lands at slot count-1.
REQ-055 Dependent op with wb port 2 matching its tag in the same cycle -> treated as ready and issues directly.
REQ-056 flush and hci_rdy=0 cases: flush with 2 in-flight ops and 5 entries -> no writebacks, count=0; hci_rdy low for 4 cycles mid-pipeline -> result appears 4 cycles later with an unchanged value.
